// File: rtl/dmem_pkg.sv
// Shared types and constants for the sized RV32 data memory.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;

    typedef enum logic {ST_INIT, ST_IDLE} state_e;

endpackage

// File: rtl/dmem_sized_if.sv
// Request/response bus between the core memory stage and the data memory.
interface dmem_sized_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              we;
    size_e             size;
    logic              uns;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] wd;
    logic              rsp_valid;
    logic [WORD_W-1:0] rd;
    logic              fault;

    modport master (
        output req_valid, we, size, uns, a, wd,
        input  req_ready, rsp_valid, rd, fault
    );

    modport slave (
        input  req_valid, we, size, uns, a, wd,
        output req_ready, rsp_valid, rd, fault
    );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module dmem_align
    import dmem_pkg::*;
(
    input  size_e             size_i,
    input  logic              uns_i,
    input  logic [1:0]        lane_i,
    input  logic [WORD_W-1:0] wd_i,
    input  logic [WORD_W-1:0] rdata_word_i,
    output logic [3:0]        byte_en_o,
    output logic [WORD_W-1:0] wdata_lanes_o,
    output logic [WORD_W-1:0] load_ext_o,
    output logic              misalign_o
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign selByte = rdata_word_i[8*lane_i +: 8];
    assign selHalf = lane_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];

    // Store data is replicated across lanes so byte_en alone picks what lands.
    always_comb begin
        byte_en_o     = 4'b0000;
        wdata_lanes_o = wd_i;
        load_ext_o    = '0;
        misalign_o    = 1'b0;
        case (size_i)
            SZ_B: begin
                byte_en_o     = 4'b0001 << lane_i;
                wdata_lanes_o = {4{wd_i[7:0]}};
                load_ext_o    = uns_i ? {24'b0, selByte} : {{24{selByte[7]}}, selByte};
            end
            SZ_H: begin
                byte_en_o     = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_lanes_o = {2{wd_i[15:0]}};
                load_ext_o    = uns_i ? {16'b0, selHalf} : {{16{selHalf[15]}}, selHalf};
                misalign_o    = lane_i[0];
            end
            SZ_W: begin
                byte_en_o     = 4'b1111;
                wdata_lanes_o = wd_i;
                load_ext_o    = rdata_word_i;
                misalign_o    = (lane_i != 2'b00);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// RV32 data memory: byte/half/word access, fault detection, optional post-reset clear,
// valid/ready request port with a registered one-cycle response.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    dmem_sized_if.slave  bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              clearWe;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [32:0]       offFull;
    logic              below, outOfRange, fault, accept, storeWe, misalign;
    logic [AW-1:0]     idx;
    logic [1:0]        lane;
    logic [3:0]        byteEn;
    logic [WORD_W-1:0] wdataLanes, loadExt, rdataWord;

    logic              rsp_valid_q;
    logic [WORD_W-1:0] rd_q;
    logic              fault_q;

    // A borrow out of the 33-bit subtraction means the address sits below BASE_ADDR.
    assign offFull    = {1'b0, bus.a} - {1'b0, BASE_ADDR};
    assign below      = offFull[32];
    assign outOfRange = |offFull[31:AW+2];
    assign idx        = offFull[AW+1:2];
    assign lane       = offFull[1:0];

    assign fault         = (bus.size == SZ_RSV) | misalign | below | outOfRange;
    assign bus.req_ready = (state_q == ST_IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign storeWe       = accept & bus.we & ~fault;
    assign rdataWord     = mem[idx];

    dmem_align u_align (
        .size_i        (bus.size),
        .uns_i         (bus.uns),
        .lane_i        (lane),
        .wd_i          (bus.wd),
        .rdata_word_i  (rdataWord),
        .byte_en_o     (byteEn),
        .wdata_lanes_o (wdataLanes),
        .load_ext_o    (loadExt),
        .misalign_o    (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Without clearing, INIT lasts one cycle so the port stays closed while in reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clearWe   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!INIT_CLEAR) begin
                    state_d = ST_IDLE;
                end else begin
                    clearWe = 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + AW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clearWe) begin
            mem[clr_cnt_q] <= '0;
        end else if (storeWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[idx][8*i +: 8] <= wdataLanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rd_q        <= '0;
            fault_q     <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            fault_q     <= accept & fault;
            rd_q        <= (accept & ~bus.we & ~fault) ? loadExt : '0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rd        = rd_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: directed and random accesses against a byte-array model,
// using a cleared 64-word instance and an uncleared 16-word instance at 0x1000.
module tb_dmem_sized;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m0 [256];
    logic [7:0]  m1 [64];
    logic [31:0] lastRd;
    logic        expFault;
    logic [31:0] expRd;
    int          n0, n1;

    always #5 clk = ~clk;

    dmem_sized_if bus0();
    dmem_sized_if bus1();

    dmem_sized #(.DEPTH(64), .BASE_ADDR(32'h0), .INIT_CLEAR(1'b1)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    dmem_sized #(.DEPTH(16), .BASE_ADDR(32'h1000), .INIT_CLEAR(1'b0)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: flat byte array per instance, little-endian, faults from address arithmetic.
    task automatic model(input int dut, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic flt, output logic [31:0] rd);
        longint base, off, val;
        int     depth, nb;
        base  = (dut == 0) ? 64'd0 : 64'h1000;
        depth = (dut == 0) ? 64 : 16;
        nb    = 1 << sz;
        off   = longint'({32'b0, a}) - base;
        flt   = 1'b0;
        rd    = '0;
        if (sz == 2'b11 || (int'(a[1:0]) % nb) != 0 || off < 0 || off / 4 >= depth) begin
            flt = 1'b1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) begin
                if (dut == 0) m0[int'(off) + i] = wd[8*i +: 8];
                else          m1[int'(off) + i] = wd[8*i +: 8];
            end
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++) begin
                if (dut == 0) val += longint'(m0[int'(off) + i]) << (8*i);
                else          val += longint'(m1[int'(off) + i]) << (8*i);
            end
            if (!uns && nb < 4 && val >= (longint'(1) << (8*nb - 1)))
                val -= longint'(1) << (8*nb);
            rd = val[31:0];
        end
    endtask

    task automatic drive(input int dut, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (dut == 0) begin
            bus0.req_valid = v; bus0.we = we; bus0.size = size_e'(sz);
            bus0.uns = uns; bus0.a = a; bus0.wd = wd;
        end else begin
            bus1.req_valid = v; bus1.we = we; bus1.size = size_e'(sz);
            bus1.uns = uns; bus1.a = a; bus1.wd = wd;
        end
    endtask

    task automatic applyStimulus(input int dut, input logic we, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd);
        drive(dut, 1'b1, we, sz, uns, a, wd);
        model(dut, we, sz, uns, a, wd, expFault, expRd);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int dut, input string tag);
        logic        v, f;
        logic [31:0] r;
        v = (dut == 0) ? bus0.rsp_valid : bus1.rsp_valid;
        f = (dut == 0) ? bus0.fault     : bus1.fault;
        r = (dut == 0) ? bus0.rd        : bus1.rd;
        lastRd = r;
        check({tag, ".valid"}, {31'b0, v}, 32'd1);
        check({tag, ".fault"}, {31'b0, f}, {31'b0, expFault});
        check({tag, ".rd"}, r, expRd);
    endtask

    task automatic doAccess(input int dut, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input string tag);
        applyStimulus(dut, we, sz, uns, a, wd);
        checkOutput(dut, tag);
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle.rsp0", {31'b0, bus0.rsp_valid}, 32'd0);
            check("idle.rsp1", {31'b0, bus1.rsp_valid}, 32'd0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".ready0"}, {31'b0, bus0.req_ready}, 32'd0);
        check({tag, ".rsp0"},   {31'b0, bus0.rsp_valid}, 32'd0);
        check({tag, ".rd0"},    bus0.rd, 32'd0);
        check({tag, ".fault0"}, {31'b0, bus0.fault}, 32'd0);
        check({tag, ".ready1"}, {31'b0, bus1.req_ready}, 32'd0);
        check({tag, ".rsp1"},   {31'b0, bus1.rsp_valid}, 32'd0);
    endtask

    task automatic releaseAndCount(output int c0, output int c1);
        c0 = -1;
        c1 = -1;
        reset = 1'b0;
        for (int c = 1; c <= 200 && (c0 < 0 || c1 < 0); c++) begin
            @(posedge clk);
            #1;
            if (c0 < 0 && bus0.req_ready) c0 = c;
            if (c1 < 0 && bus1.req_ready) c1 = c;
        end
    endtask

    initial begin
        logic        rWe, rUns;
        logic [1:0]  rSz;
        logic [31:0] rA;

        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");

        releaseAndCount(n0, n1);
        check("init.len", n0, 32'd64);
        check("u1.ready_after_reset", n1, 32'd1);
        for (int i = 0; i < 256; i++) m0[i] = 8'h00;

        for (int w = 0; w < 64; w++) doAccess(0, 1'b0, 2'b10, 1'b0, w * 4, 32'h0, "clr.lw");
        for (int w = 0; w < 64; w++) doAccess(0, 1'b1, 2'b10, 1'b0, w * 4, $urandom, "fill.sw");
        idle(1);

        doAccess(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8180_7F01, "t2.sw");
        doAccess(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "t2.lb11");
        check("t2.lit.lb11", lastRd, 32'h0000_007F);
        doAccess(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "t2.lb12");
        check("t2.lit.lb12", lastRd, 32'hFFFF_FF80);
        doAccess(0, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, "t2.lbu12");
        check("t2.lit.lbu12", lastRd, 32'h0000_0080);
        doAccess(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "t2.lh12");
        check("t2.lit.lh12", lastRd, 32'hFFFF_8180);
        doAccess(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "t2.lhu12");
        check("t2.lit.lhu12", lastRd, 32'h0000_8180);

        doAccess(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, "t3.sw");
        doAccess(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0055, "t3.sb");
        doAccess(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234, "t3.sh");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "t3.lw");
        check("t3.lit.lw", lastRd, 32'h1234_55DD);

        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, "t4.lw_mis");
        doAccess(0, 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, "t4.lh_mis");
        doAccess(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, "t4.rsv_ld");
        doAccess(0, 1'b1, 2'b11, 1'b0, 32'h04, 32'h1111_1111, "t4.rsv_st");
        doAccess(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, "t4.sw_oor");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, "t4.lw_oor");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, "t4.lw_alias");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, "t4.lw_rsv_nowrite");
        doAccess(1, 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'h0, "t4.u1_below");
        doAccess(1, 1'b0, 2'b10, 1'b0, 32'h1040, 32'h0, "t4.u1_above");
        doAccess(1, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFE_F00D, "t4.u1_sw");
        doAccess(1, 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, "t4.u1_lw");
        doAccess(1, 1'b1, 2'b00, 1'b0, 32'h103F, 32'h0000_009A, "t4.u1_sb_top");
        doAccess(1, 1'b0, 2'b00, 1'b0, 32'h103F, 32'h0, "t4.u1_lb_top");
        idle(1);

        doAccess(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0000_0001, "t5.sw");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, "t5.lw");
        check("t5.lit.lw", lastRd, 32'h0000_0001);
        doAccess(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF, "t5.sh");
        doAccess(0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, "t5.lhu");
        doAccess(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, "t5.lw2");

        for (int k = 0; k < 300; k++) begin
            rWe  = 1'($urandom_range(0, 1));
            rSz  = 2'($urandom_range(0, 3));
            rUns = 1'($urandom_range(0, 1));
            rA   = $urandom_range(0, 32'h10F);
            doAccess(0, rWe, rSz, rUns, rA, $urandom, "rand");
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkResetOutputs("t6.rst_inflight");
        drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("t6.rst_hold");
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6.midinit.ready", {31'b0, bus0.req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        checkResetOutputs("t6.rst_midinit");
        @(posedge clk);
        #1;
        releaseAndCount(n0, n1);
        check("t6.init.len", n0, 32'd64);
        check("t6.u1_ready", n1, 32'd1);
        for (int i = 0; i < 256; i++) m0[i] = 8'h00;
        for (int w = 0; w < 64; w++) doAccess(0, 1'b0, 2'b10, 1'b0, w * 4, 32'h0, "t6.clr.lw");
        doAccess(1, 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, "t6.u1_retain");
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
